// File: rtl/upscale_addr_gen_if.sv
`default_nettype none
// ============================================================================
// Module   : upscale_addr_gen_if
// Brief    : Pixel-in / config / framebuffer-read bundle for upscale_addr_gen.
// Revision : 1.0
// ============================================================================
interface upscale_addr_gen_if #(
  parameter int COORD_W = 11,
  parameter int ADDR_W  = 15
);
  logic               pix_valid;
  logic [COORD_W-1:0] pix_x;
  logic [COORD_W-1:0] pix_y;
  logic               cfg_wr;
  logic [1:0]         cfg_shift_x;
  logic [1:0]         cfg_shift_y;
  logic [COORD_W-1:0] cfg_off_x;
  logic [COORD_W-1:0] cfg_off_y;
  logic               cfg_pending;
  logic               rd_valid;
  logic [ADDR_W-1:0]  rd_addr;
  logic               in_image;

  modport master (
    output pix_valid, pix_x, pix_y,
    output cfg_wr, cfg_shift_x, cfg_shift_y, cfg_off_x, cfg_off_y,
    input  cfg_pending, rd_valid, rd_addr, in_image
  );

  modport slave (
    input  pix_valid, pix_x, pix_y,
    input  cfg_wr, cfg_shift_x, cfg_shift_y, cfg_off_x, cfg_off_y,
    output cfg_pending, rd_valid, rd_addr, in_image
  );
endinterface
`default_nettype wire

// File: rtl/upscale_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : upscale_addr_gen
// Brief    : 2-stage display-pixel to framebuffer-address mapper with shadowed
//            per-axis power-of-two scale and letterbox offset.
// Revision : 1.0
// ============================================================================
module upscale_addr_gen #(
  parameter int BUF_W       = 160,
  parameter int BUF_H       = 120,
  parameter int COORD_W     = 11,
  parameter int ADDR_W      = 15,
  parameter int MAX_SHIFT   = 3,
  parameter int RST_SHIFT_X = 2,
  parameter int RST_SHIFT_Y = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  upscale_addr_gen_if.slave   bus
);

  localparam logic [1:0] c_MAX_SH = 2'(MAX_SHIFT);
  localparam logic [1:0] c_RST_SX = 2'(RST_SHIFT_X);
  localparam logic [1:0] c_RST_SY = 2'(RST_SHIFT_Y);

  logic               r_pend;
  logic [1:0]         r_pnd_sx, r_pnd_sy, r_act_sx, r_act_sy;
  logic [COORD_W-1:0] r_pnd_ox, r_pnd_oy, r_act_ox, r_act_oy;

  logic               w_fs, w_apply;
  logic [1:0]         w_req_sx, w_req_sy, w_sx, w_sy;
  logic [COORD_W-1:0] w_ox, w_oy;
  logic [COORD_W:0]   w_rx, w_ry;
  logic [COORD_W+3:0] w_lim_x, w_lim_y;
  logic               w_in;

  assign w_fs     = bus.pix_valid && (bus.pix_x == '0) && (bus.pix_y == '0);
  assign w_apply  = w_fs && r_pend;
  assign w_req_sx = (bus.cfg_shift_x > c_MAX_SH) ? c_MAX_SH : bus.cfg_shift_x;
  assign w_req_sy = (bus.cfg_shift_y > c_MAX_SH) ? c_MAX_SH : bus.cfg_shift_y;

  // The frame-start pixel itself already sees the config being promoted.
  assign w_sx = w_apply ? r_pnd_sx : r_act_sx;
  assign w_sy = w_apply ? r_pnd_sy : r_act_sy;
  assign w_ox = w_apply ? r_pnd_ox : r_act_ox;
  assign w_oy = w_apply ? r_pnd_oy : r_act_oy;

  assign w_rx    = {1'b0, bus.pix_x} - {1'b0, w_ox};
  assign w_ry    = {1'b0, bus.pix_y} - {1'b0, w_oy};
  assign w_lim_x = (COORD_W+4)'(BUF_W) << w_sx;
  assign w_lim_y = (COORD_W+4)'(BUF_H) << w_sy;
  assign w_in    = !w_rx[COORD_W] && ((COORD_W+4)'(w_rx[COORD_W-1:0]) < w_lim_x) &&
                   !w_ry[COORD_W] && ((COORD_W+4)'(w_ry[COORD_W-1:0]) < w_lim_y);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend   <= 1'b0;
      r_pnd_sx <= c_RST_SX;
      r_pnd_sy <= c_RST_SY;
      r_pnd_ox <= '0;
      r_pnd_oy <= '0;
      r_act_sx <= c_RST_SX;
      r_act_sy <= c_RST_SY;
      r_act_ox <= '0;
      r_act_oy <= '0;
    end else begin
      if (w_apply) begin
        r_act_sx <= r_pnd_sx;
        r_act_sy <= r_pnd_sy;
        r_act_ox <= r_pnd_ox;
        r_act_oy <= r_pnd_oy;
      end
      if (bus.cfg_wr) begin
        r_pend   <= 1'b1;
        r_pnd_sx <= w_req_sx;
        r_pnd_sy <= w_req_sy;
        r_pnd_ox <= bus.cfg_off_x;
        r_pnd_oy <= bus.cfg_off_y;
      end else if (w_apply) begin
        r_pend <= 1'b0;
      end
    end
  end

  logic               r1_valid, r1_in;
  logic [COORD_W-1:0] r1_rx, r1_ry;
  logic [1:0]         r1_sx, r1_sy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r1_valid <= 1'b0;
      r1_in    <= 1'b0;
      r1_rx    <= '0;
      r1_ry    <= '0;
      r1_sx    <= '0;
      r1_sy    <= '0;
    end else begin
      r1_valid <= bus.pix_valid;
      if (bus.pix_valid) begin
        r1_in <= w_in;
        r1_rx <= w_rx[COORD_W-1:0];
        r1_ry <= w_ry[COORD_W-1:0];
        r1_sx <= w_sx;
        r1_sy <= w_sy;
      end
    end
  end

  logic [COORD_W-1:0] w_col, w_row;
  logic [ADDR_W-1:0]  w_addr;

  // Range check in stage 1 bounds col < BUF_W and row < BUF_H here.
  assign w_col  = r1_rx >> r1_sx;
  assign w_row  = r1_ry >> r1_sy;
  assign w_addr = ADDR_W'(w_row) * ADDR_W'(BUF_W) + ADDR_W'(w_col);

  logic              r2_valid, r2_in;
  logic [ADDR_W-1:0] r2_addr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r2_valid <= 1'b0;
      r2_in    <= 1'b0;
      r2_addr  <= '0;
    end else begin
      r2_valid <= r1_valid;
      if (r1_valid) begin
        r2_in   <= r1_in;
        r2_addr <= r1_in ? w_addr : '0;
      end
    end
  end

  assign bus.rd_valid    = r2_valid;
  assign bus.rd_addr     = r2_addr;
  assign bus.in_image    = r2_in;
  assign bus.cfg_pending = r_pend;

endmodule
`default_nettype wire

// File: tb/tb_upscale_addr_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_upscale_addr_gen
// Brief    : Directed self-checking bench for upscale_addr_gen.
// Revision : 1.0
// ============================================================================
module tb_upscale_addr_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_chk = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  upscale_addr_gen_if #(.COORD_W(11), .ADDR_W(15)) bus ();
  upscale_addr_gen_if #(.COORD_W(11), .ADDR_W(15)) bus2 ();

  upscale_addr_gen u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  upscale_addr_gen #(
    .MAX_SHIFT   (1),
    .RST_SHIFT_X (1),
    .RST_SHIFT_Y (1)
  ) u_dut_clamp1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus2)
  );

  assign bus2.pix_valid   = bus.pix_valid;
  assign bus2.pix_x       = bus.pix_x;
  assign bus2.pix_y       = bus.pix_y;
  assign bus2.cfg_wr      = bus.cfg_wr;
  assign bus2.cfg_shift_x = bus.cfg_shift_x;
  assign bus2.cfg_shift_y = bus.cfg_shift_y;
  assign bus2.cfg_off_x   = bus.cfg_off_x;
  assign bus2.cfg_off_y   = bus.cfg_off_y;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive_pix(input logic v, input int x, input int y);
    bus.pix_valid = v;
    bus.pix_x     = 11'(x);
    bus.pix_y     = 11'(y);
  endtask

  task automatic cfg(input int sx, input int sy, input int ox, input int oy);
    bus.cfg_shift_x = 2'(sx);
    bus.cfg_shift_y = 2'(sy);
    bus.cfg_off_x   = 11'(ox);
    bus.cfg_off_y   = 11'(oy);
    bus.cfg_wr      = 1'b1;
    tick();
    bus.cfg_wr      = 1'b0;
  endtask

  task automatic send(input string tag, input int x, input int y,
                      input logic in_exp, input int addr_exp);
    drive_pix(1'b1, x, y);
    tick();
    drive_pix(1'b0, 0, 0);
    tick();
    chk({tag, ".valid"}, 32'(bus.rd_valid), 32'(1));
    chk({tag, ".in"},    32'(bus.in_image), 32'(in_exp));
    chk({tag, ".addr"},  32'(bus.rd_addr),  32'(addr_exp));
  endtask

  int pv [6] = '{1, 0, 1, 1, 0, 0};
  int px [6] = '{16, 0, 24, 40, 0, 0};
  int py [6] = '{8, 0, 16, 0, 0, 0};
  int rv [6] = '{0, 0, 1, 0, 1, 1};
  int ra [6] = '{0, 0, 162, 162, 323, 5};

  initial begin
    drive_pix(1'b0, 0, 0);
    bus.cfg_wr = 1'b0;
    bus.cfg_shift_x = '0;
    bus.cfg_shift_y = '0;
    bus.cfg_off_x = '0;
    bus.cfg_off_y = '0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    chk("rst.valid",   32'(bus.rd_valid),    32'(0));
    chk("rst.addr",    32'(bus.rd_addr),     32'(0));
    chk("rst.in",      32'(bus.in_image),    32'(0));
    chk("rst.pending", 32'(bus.cfg_pending), 32'(0));

    // Default 4x, no offset
    send("def00",  0,   0,   1'b1, 0);
    send("def75",  7,   5,   1'b1, 161);
    send("defmax", 639, 479, 1'b1, 19199);

    // Mixed scale 2x/4x with a 160-pixel left border
    cfg(1, 2, 160, 0);
    chk("mix.pending", 32'(bus.cfg_pending), 32'(1));
    send("mix00",   0,   0, 1'b0, 0);
    chk("mix.pending_clr", 32'(bus.cfg_pending), 32'(0));
    send("mix160",  160, 0, 1'b1, 0);
    send("mix479",  479, 9, 1'b1, 479);
    // Column 160 would wrap into the next row, so it is border
    send("mix481",  481, 9, 1'b0, 0);
    send("mix480",  480, 0, 1'b0, 0);

    // Mid-frame config write stays pending until the next frame start
    bus.cfg_shift_x = 2'd0;
    bus.cfg_shift_y = 2'd0;
    bus.cfg_off_x   = 11'd0;
    bus.cfg_off_y   = 11'd0;
    bus.cfg_wr      = 1'b1;
    drive_pix(1'b1, 300, 50);
    tick();
    bus.cfg_wr = 1'b0;
    drive_pix(1'b0, 0, 0);
    tick();
    chk("shd.addr_old",  32'(bus.rd_addr),     32'(1990));
    chk("shd.pending",   32'(bus.cfg_pending), 32'(1));
    send("shd302", 302, 52, 1'b1, 2151);
    chk("shd.pending2",  32'(bus.cfg_pending), 32'(1));
    drive_pix(1'b1, 0, 0);
    tick();
    chk("shd.pending_clr", 32'(bus.cfg_pending), 32'(0));
    drive_pix(1'b0, 0, 0);
    tick();
    chk("shd00.in",   32'(bus.in_image), 32'(1));
    chk("shd00.addr", 32'(bus.rd_addr),  32'(0));
    send("shd1x_max", 159, 119, 1'b1, 19199);
    send("shd1x_out", 160, 0,   1'b0, 0);

    // Last write before frame start wins
    cfg(3, 0, 0, 0);
    cfg(2, 0, 0, 0);
    send("lw00", 0, 0, 1'b1, 0);
    send("lw93", 9, 3, 1'b1, 482);

    // Shift 3: legal on the default instance, clamped to 1 on the MAX_SHIFT=1 one
    cfg(3, 3, 0, 0);
    send("cl00", 0, 0, 1'b1, 0);
    send("cl93", 9, 3, 1'b1, 1);
    chk("clamp1.in",   32'(bus2.in_image), 32'(1));
    chk("clamp1.addr", 32'(bus2.rd_addr),  32'(164));

    // Bubbles: 1,0,1,1 in gives 0,0,1,0,1,1 out with held outputs in the gap
    tick();
    for (int i = 0; i < 6; i++) begin
      drive_pix(pv[i] != 0, px[i], py[i]);
      chk($sformatf("bub%0d.valid", i), 32'(bus.rd_valid), 32'(rv[i]));
      if (i >= 2)
        chk($sformatf("bub%0d.addr", i), 32'(bus.rd_addr), 32'(ra[i]));
      tick();
    end
    drive_pix(1'b0, 0, 0);

    // Asynchronous reset with pixels in flight and a config pending
    cfg(0, 0, 0, 0);
    chk("ar.pending_set", 32'(bus.cfg_pending), 32'(1));
    drive_pix(1'b1, 16, 8);
    tick();
    drive_pix(1'b1, 24, 16);
    tick();
    chk("ar.inflight", 32'(bus.rd_valid), 32'(1));
    #2 rst_n = 1'b0;
    drive_pix(1'b0, 0, 0);
    #1;
    chk("ar.valid",   32'(bus.rd_valid),    32'(0));
    chk("ar.addr",    32'(bus.rd_addr),     32'(0));
    chk("ar.in",      32'(bus.in_image),    32'(0));
    chk("ar.pending", 32'(bus.cfg_pending), 32'(0));
    #2 rst_n = 1'b1;
    tick();
    chk("ar.stale1", 32'(bus.rd_valid), 32'(0));
    tick();
    chk("ar.stale2", 32'(bus.rd_valid), 32'(0));
    send("ar00", 0, 0, 1'b1, 0);
    send("ar75", 7, 5, 1'b1, 161);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
